// File: rtl/wtu_lvl_n.sv
// Multi-level Haar wavelet unit: LEVELS cascaded pair stages, one tagged coefficient stream out.
// One register stage per level; output selection is registered and held while out_ready is low.
module wtu_lvl_n #(
  parameter int DATA_W = 24,
  parameter int LEVELS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [2:0]               out_lvl,
  output logic                     out_hp,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int L = LEVELS;
  typedef logic signed [DATA_W-1:0] smp_t;
  localparam smp_t SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam smp_t SMAX = ~SMIN;

  smp_t       in_reg [L];
  smp_t       a_reg  [L];
  smp_t       hp_reg [L];
  smp_t       lp_reg;
  logic [L-1:0] in_full, have_a, hp_full;
  logic       lp_full;
  logic [2:0] grant;

  smp_t       lp_val   [L];
  smp_t       hp_val   [L];
  smp_t       n_hp_reg [L];
  smp_t       n_lp_reg;
  smp_t       n_data;
  logic [L-1:0] clr_hp, take, pair, load_in, n_hp_full;
  logic [L:0] room;
  logic       hs, clr_lp, n_lp_full, n_found, n_hp;
  logic [2:0] n_grant, n_lvl;

  for (genvar g = 0; g < L; g++) begin : g_arith
    logic signed [DATA_W:0] sum, dif;
    assign sum = {a_reg[g][DATA_W-1], a_reg[g]} + {in_reg[g][DATA_W-1], in_reg[g]};
    assign dif = {a_reg[g][DATA_W-1], a_reg[g]} - {in_reg[g][DATA_W-1], in_reg[g]};
    assign lp_val[g] = sum[DATA_W:1];
    assign hp_val[g] = (dif[DATA_W] != dif[DATA_W-1]) ? (dif[DATA_W] ? SMIN : SMAX)
                                                      : dif[DATA_W-1:0];
  end

  always_comb begin
    hs     = out_valid && out_ready;
    clr_lp = hs && (grant == 3'(L));
    for (int i = 0; i < L; i++) clr_hp[i] = hs && (grant == 3'(i));

    // Walk from the output back so each level sees whether its downstream slot frees up.
    room    = '0;
    take    = '0;
    pair    = '0;
    room[L] = !lp_full || clr_lp;
    for (int i = L - 1; i >= 0; i--) begin
      pair[i] = in_full[i] && have_a[i] && (!hp_full[i] || clr_hp[i]) && room[i+1];
      take[i] = in_full[i] && (!have_a[i] || pair[i]);
      room[i] = !in_full[i] || take[i];
    end
    in_ready = !rst && room[0];

    load_in    = '0;
    load_in[0] = in_valid && in_ready;
    for (int i = 1; i < L; i++) load_in[i] = pair[i-1];

    for (int i = 0; i < L; i++) begin
      n_hp_full[i] = (hp_full[i] && !clr_hp[i]) || pair[i];
      n_hp_reg[i]  = pair[i] ? hp_val[i] : hp_reg[i];
    end
    n_lp_full = (lp_full && !clr_lp) || pair[L-1];
    n_lp_reg  = pair[L-1] ? lp_val[L-1] : lp_reg;

    // Lowest level wins; the low band only when no high band is pending.
    n_found = n_lp_full;
    n_grant = 3'(L);
    n_data  = n_lp_reg;
    n_lvl   = 3'(L);
    n_hp    = 1'b0;
    for (int i = L - 1; i >= 0; i--) begin
      if (n_hp_full[i]) begin
        n_found = 1'b1;
        n_grant = 3'(i);
        n_data  = n_hp_reg[i];
        n_lvl   = 3'(i + 1);
        n_hp    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_full   <= '0;
      have_a    <= '0;
      hp_full   <= '0;
      lp_full   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lvl   <= '0;
      out_hp    <= 1'b0;
      grant     <= '0;
    end else begin
      in_full <= (in_full & ~take) | load_in;
      have_a  <= have_a ^ take;
      hp_full <= n_hp_full;
      lp_full <= n_lp_full;
      if (!out_valid || out_ready) begin
        out_valid <= n_found;
        grant     <= n_grant;
        if (n_found) begin
          out_data <= n_data;
          out_lvl  <= n_lvl;
          out_hp   <= n_hp;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_in[0]) in_reg[0] <= in_data;
    for (int i = 1; i < L; i++) begin
      if (load_in[i]) in_reg[i] <= lp_val[i-1];
    end
    for (int i = 0; i < L; i++) begin
      if (take[i] && !have_a[i]) a_reg[i] <= in_reg[i];
      hp_reg[i] <= n_hp_reg[i];
    end
    lp_reg <= n_lp_reg;
  end

endmodule

// File: tb/tb_wtu_lvl_n.sv
// Bench for wtu_lvl_n: per-band expected queues from a pair-cascade model, plus literal cases.
module tb_wtu_lvl_n;
  localparam int W = 24;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [W-1:0] out_data;
  logic [2:0] out_lvl;
  logic out_hp, out_valid;
  logic out_ready = 1'b1;

  always #5 clk = ~clk;

  wtu_lvl_n #(.DATA_W(W), .LEVELS(L)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_lvl(out_lvl), .out_hp(out_hp),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct { int lvl; bit hp; longint val; } coef_t;
  coef_t exp_q[$];
  coef_t got_q[$];
  longint pa[1:L];
  bit     ph[1:L];

  int vectors = 0, miscompares = 0;
  int cyc = 0, mode = 0;
  int last_acc_cyc = 0, first_ov_cyc = -1;
  bit stall_win = 0, saw_ir_low = 0;
  bit prev_valid = 0, prev_ready = 0, prev_hp = 0;
  logic signed [W-1:0] prev_data = '0;
  logic [2:0] prev_lvl = '0;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint sat(input longint d);
    longint mx, mn;
    mx = (longint'(1) <<< (W - 1)) - 1;
    mn = -(longint'(1) <<< (W - 1));
    if (d > mx) return mx;
    if (d < mn) return mn;
    return d;
  endfunction

  // Pair samples level by level; each completed pair yields a high band and passes its low band on.
  function automatic void model_push(input longint v);
    longint cur, a;
    int k;
    cur = v;
    k = 1;
    while (k <= L) begin
      if (!ph[k]) begin
        pa[k] = cur;
        ph[k] = 1;
        break;
      end
      ph[k] = 0;
      a = pa[k];
      exp_q.push_back('{lvl: k, hp: 1'b1, val: sat(a - cur)});
      cur = (a + cur) >>> 1;
      if (k == L) begin
        exp_q.push_back('{lvl: k, hp: 1'b0, val: cur});
        break;
      end
      k++;
    end
  endfunction

  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1'b1;
      2: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    int idx;
    cyc++;
    if (rst) begin
      exp_q.delete();
      for (int k = 1; k <= L; k++) ph[k] = 0;
      check("rst_in_ready", longint'(in_ready), 0);
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_data", longint'(out_data), longint'(prev_data));
        check("hold_lvl", longint'(out_lvl), longint'(prev_lvl));
        check("hold_hp", longint'(out_hp), longint'(prev_hp));
      end
      if (in_valid && in_ready) begin
        model_push(longint'(in_data));
        last_acc_cyc = cyc;
      end
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
      if (stall_win && !in_ready) saw_ir_low = 1;
      if (out_valid && out_ready) begin
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (exp_q[i].lvl == int'(out_lvl) && exp_q[i].hp == out_hp) begin
            idx = i;
            break;
          end
        end
        if (idx < 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_coef: got %0d lvl %0d hp %0d, expected none pending",
                   out_data, out_lvl, out_hp);
        end else begin
          check($sformatf("coef_L%0d_hp%0d", out_lvl, out_hp), longint'(out_data), exp_q[idx].val);
          exp_q.delete(idx);
        end
        got_q.push_back('{lvl: int'(out_lvl), hp: out_hp, val: longint'(out_data)});
      end
    end
    prev_valid = out_valid && !rst;
    prev_ready = out_ready;
    prev_data  = out_data;
    prev_lvl   = out_lvl;
    prev_hp    = out_hp;
  end

  task automatic send_one(input longint v);
    bit acc;
    in_valid = 1'b1;
    in_data  = v[W-1:0];
    acc = 0;
    for (int n = 0; n < 300 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic drain(input int budget);
    in_valid = 1'b0;
    for (int n = 0; n < budget && (exp_q.size() != 0 || out_valid); n++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_got(input int i, input longint val, input int lvl, input bit hp);
    if (got_q.size() > i) begin
      check($sformatf("lit%0d_val", i), got_q[i].val, val);
      check($sformatf("lit%0d_lvl", i), got_q[i].lvl, lvl);
      check($sformatf("lit%0d_hp", i), got_q[i].hp, hp);
    end else begin
      check($sformatf("lit%0d_present", i), got_q.size(), i + 1);
    end
  endtask

  initial begin
    int acc4;
    longint v;

    // Reset held with in_valid high: nothing accepted, nothing emitted.
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 24'sd123;
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid", longint'(out_valid), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("ready_after_rst", longint'(in_ready), 1);
    repeat (3) begin
      @(negedge clk);
      check("idle_out_valid", longint'(out_valid), 0);
    end

    // 10,4,7,1: two L1 high bands of 6, then the L2 high band 3.
    do_reset();
    first_ov_cyc = -1;
    send_one(10);
    send_one(4);
    acc4 = last_acc_cyc;
    send_one(7);
    send_one(1);
    idle(8);
    check("first_latency", first_ov_cyc - acc4, 2);
    check("lit_a_count", got_q.size(), 3);
    check_got(0, 6, 1, 1);
    check_got(1, 6, 1, 1);
    check_got(2, 3, 2, 1);

    // Saturation of the high band in both directions.
    do_reset();
    send_one(8388607);
    send_one(-8388608);
    idle(5);
    check_got(0, 8388607, 1, 1);
    do_reset();
    send_one(-8388608);
    send_one(8388607);
    idle(5);
    check_got(0, -8388608, 1, 1);

    // Floor rounding of the low band: (-3+0)>>>1 = -2 through every level.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      send_one(-3);
      send_one(0);
    end
    idle(14);
    check("lit_c_count", got_q.size(), 8);
    check_got(0, -3, 1, 1);
    check_got(6, 0, 3, 1);
    check_got(7, -2, 3, 0);

    // 64-sample ramp with a 20-cycle output stall mid-stream.
    do_reset();
    saw_ir_low = 0;
    fork
      for (int i = 0; i < 64; i++) send_one(longint'(i) * 1000 - 31000);
      begin
        repeat (16) @(posedge clk);
        mode = 2;
        repeat (L + 3) @(posedge clk);
        stall_win = 1;
        repeat (20 - (L + 3)) @(posedge clk);
        stall_win = 0;
        mode = 0;
      end
    join
    drain(400);
    check("stall_in_ready_low", saw_ir_low, 1);
    check("ramp_count", got_q.size(), 64);

    // Random samples, random input gaps and 50% out_ready.
    do_reset();
    mode = 1;
    for (int i = 0; i < 128; i++) begin
      idle($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0: v = 8388607;
        1: v = -8388608;
        default: v = longint'($signed(24'($urandom)));
      endcase
      send_one(v);
    end
    drain(1000);
    mode = 0;
    check("rand_count", got_q.size(), 128);

    // Reset mid-stream discards everything held before it.
    do_reset();
    for (int i = 1; i <= 5; i++) send_one(i);
    idle(3);
    do_reset();
    send_one(2);
    send_one(8);
    idle(10);
    check("post_rst_count", got_q.size(), 1);
    check_got(0, -6, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
